bcd_time_countdown: RTL

Sequential hh:mm:ss countdown timer that operates directly on packed-BCD time fields. It accepts a BCD time, either as a direct duration or, optionally, as an RTC time-of-day converted to its complement against end of day. It then decrements once per prescaled tick until 00:00:00. It sits between the RTC register interface and the display/alarm logic, and generalises the fixed end-of-day subtraction with a parametrised hour limit, range checking and real count-down behaviour.

---
 rtl/bcd_time_countdown.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bcd_time_countdown.sv
// hh:mm:ss packed-BCD countdown timer with validated load and a prescaled one-second tick.
// Optional feature macro: BCD_CD_COMPLEMENT_EN (load_comp=1 loads time remaining to end of day).
module bcd_time_countdown #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_valid_i,
  output logic       load_ready_o,
  input  logic       load_comp_i,
  input  logic [7:0] hora_in_i,
  input  logic [7:0] minuto_in_i,
  input  logic [7:0] segundo_in_i,
  input  logic       start_i,
  input  logic       stop_i,
  output logic [7:0] hora_out_o,
  output logic [7:0] minuto_out_o,
  output logic [7:0] segundo_out_o,
  output logic       running_o,
  output logic       done_o,
  output logic       load_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_e;

  localparam int PW = 27;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [23:0]     time_q, time_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [7:0]      hour_bin;
  logic            load_ok;
  logic [23:0]     load_time;
  logic [23:0]     time_dec;
  logic            tick;

  assign hour_bin = 8'(hora_in_i[7:4]) * 8'd10 + 8'(hora_in_i[3:0]);
  assign load_ok  = (hora_in_i[7:4] <= 4'd9) && (hora_in_i[3:0] <= 4'd9) &&
                    (minuto_in_i[7:4] <= 4'd5) && (minuto_in_i[3:0] <= 4'd9) &&
                    (segundo_in_i[7:4] <= 4'd5) && (segundo_in_i[3:0] <= 4'd9) &&
                    (hour_bin <= 8'(HOUR_MAX));

`ifdef BCD_CD_COMPLEMENT_EN
  logic [7:0] hour_cbin;
  logic [3:0] hc_tens, hc_units;
  assign hour_cbin = 8'(HOUR_MAX) - hour_bin;
  assign hc_tens   = 4'(hour_cbin / 8'd10);
  assign hc_units  = 4'(hour_cbin % 8'd10);
  // Minutes/seconds complement digit-wise since the validated tens digit is <= 5.
  assign load_time = load_comp_i ?
    {hc_tens, hc_units,
     4'd5 - minuto_in_i[7:4], 4'd9 - minuto_in_i[3:0],
     4'd5 - segundo_in_i[7:4], 4'd9 - segundo_in_i[3:0]} :
    {hora_in_i, minuto_in_i, segundo_in_i};
`else
  logic unused_load_comp;
  assign unused_load_comp = load_comp_i;
  assign load_time = {hora_in_i, minuto_in_i, segundo_in_i};
`endif

  function automatic logic [23:0] dec_time(input logic [23:0] t);
    logic [3:0] ht, hu, mt, mu, st, su;
    {ht, hu, mt, mu, st, su} = t;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          if (mt != 4'd0) mt = mt - 4'd1;
          else begin
            mt = 4'd5;
            if (hu != 4'd0) hu = hu - 4'd1;
            else begin
              hu = 4'd9;
              ht = ht - 4'd1;
            end
          end
        end
      end
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  assign time_dec = dec_time(time_q);
  assign tick     = (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == S_RUN) begin
      // The prescaler advances on every RUN cycle, including the one that sees stop.
      if (tick) begin
        presc_d = '0;
        time_d  = time_dec;
        if (time_dec == 24'h0) begin
          state_d = S_EXPIRED;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (stop_i && !(tick && time_dec == 24'h0)) state_d = S_PAUSED;
    end else if (load_valid_i) begin
      if (load_ok) begin
        time_d  = load_time;
        state_d = S_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (start_i && !stop_i && state_q != S_EXPIRED && time_q != 24'h0) begin
      if (state_q == S_IDLE) presc_d = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      time_q  <= 24'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign hora_out_o    = time_q[23:16];
  assign minuto_out_o  = time_q[15:8];
  assign segundo_out_o = time_q[7:0];
  assign running_o     = (state_q == S_RUN);
  assign load_ready_o  = (state_q != S_RUN);
  assign done_o        = done_q;
  assign load_err_o    = err_q;

endmodule
